core_link_fifo: RTL and testbench
=================================

CORE_LINK_FIFO -- requirements
Module: core_link_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `MAC_MULT_NUM*`IDATA_WIDTH, giving the link word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entry count; legal values are powers of two >= 2, and other values are an elaboration error.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-1, giving the occupancy at or above which hlink_afull asserts.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port hlink_wdata, input, width DATA_WIDTH: write word.
REQ-007 SHALL have port hlink_wvalid, input, width 1: the writer offers hlink_wdata.
REQ-008 SHALL have port hlink_wready, output, width 1: the FIFO can accept a word.
REQ-009 SHALL have port hlink_rdata, output, width DATA_WIDTH: the head word.
REQ-010 SHALL have port hlink_rvalid, output, width 1: hlink_rdata is valid.
REQ-011 SHALL have port hlink_rready, input, width 1: the reader consumes the head word.
REQ-012 SHALL have port hlink_count, output, width $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 SHALL have port hlink_afull, output, width 1: asserted when hlink_count >= AFULL_THRESH.

Function
REQ-014 SHALL accept a write (push) in a cycle where hlink_wvalid && hlink_wready.
REQ-015 SHALL pop in a cycle where hlink_rvalid && hlink_rready.
REQ-016 SHALL drive hlink_wready = (hlink_count != DEPTH), combinationally from registered state only; hlink_wready SHALL NOT depend on hlink_rready, so a full FIFO does not accept a write even while it pops.
REQ-017 SHALL drive hlink_rvalid = (hlink_count != 0); hlink_rdata SHALL equal the oldest unpopped entry and remain stable until popped.
REQ-018 SHALL make a word pushed on edge N visible on hlink_rdata/hlink_rvalid after edge N, i.e. 1-cycle latency (bypass disabled).
REQ-019 SHALL implement read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and pointers wrap modulo 2*DEPTH.
REQ-020 SHALL update hlink_count on a simultaneous push and pop (count between 1 and DEPTH-1) by: count unchanged, both pointers advanced.
REQ-021 SHALL ignore hlink_rready while empty and hlink_wvalid while full, with no state change and no error.
REQ-022 SHALL preserve strict FIFO order and never drop or duplicate an accepted word.

Reset
REQ-023 SHALL, while rstn is low, asynchronously force pointers = 0, hlink_count = 0, hlink_rvalid = 0, hlink_wready = 1, hlink_afull = (AFULL_THRESH == 0), and all storage entries and hlink_rdata = 0.
REQ-024 SHALL, on reset asserted mid-operation, discard all stored words; the first push after release is the first word read out.

Configuration
REQ-025 SHALL, with macro CORE_LINK_FIFO_BYPASS_EN defined, present hlink_wdata on hlink_rdata with hlink_rvalid = 1 in the same cycle when the FIFO is empty and hlink_wvalid = 1; if hlink_rready is also 1 the word SHALL be consumed without being stored (count stays 0), otherwise it SHALL be stored as in REQ-014.
REQ-026 SHALL, without CORE_LINK_FIFO_BYPASS_EN, have no combinational path from any write-side input to hlink_rdata or hlink_rvalid.

Structure
REQ-027 SHALL take `MAC_MULT_NUM and `IDATA_WIDTH from sys_defs.svh; the pointer-width helper function SHALL live in a shared package, core_link_pkg, reused by later link blocks.
REQ-028 SHALL place storage in the sub-module core_link_fifo_mem (DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port, async reset); pointers, count and flags SHALL remain in core_link_fifo.

Verification (DATA_WIDTH=16, DEPTH=4, AFULL_THRESH=3)
REQ-029 SHALL check fill: push 0x0001..0x0004 with hlink_rready=0 -> count 1,2,3,4; hlink_afull from count 3; hlink_wready=0 at count 4; a 5th push of 0x0005 is not accepted.
REQ-030 SHALL check drain: from full, hold hlink_rready=1 -> reads 0x0001..0x0004 on consecutive cycles, then hlink_rvalid=0 and count 0.
REQ-031 SHALL check streaming: continuous push of 0x0010+i with hlink_rready=1 -> count steady at 1 and output in order; run 10 words to exercise pointer wrap.
REQ-032 SHALL check full with pop: full plus hlink_rready=1 and hlink_wvalid=1 -> pop occurs, write is refused that cycle, and count becomes 3.
REQ-033 SHALL check reset mid-stream: rstn low with count=2 -> outputs at reset values immediately; after release, push 0x00AA reads 0x00AA first.
REQ-034 SHALL check bypass: with CORE_LINK_FIFO_BYPASS_EN defined and empty, push 0x00BB with hlink_rready=1 -> hlink_rdata=0x00BB and hlink_rvalid=1 in the same cycle, and count stays 0; without the macro, hlink_rvalid rises one cycle later.

Source files
------------

// File: rtl/core_link_pkg.sv
// Shared helpers for the core link blocks: pointer sizing and depth legality.
package core_link_pkg;

    // One extra MSB beyond the address lets full and empty be told apart.
    function automatic int link_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit link_is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/core_link_fifo_mem.sv
// Link FIFO storage: one synchronous write port, one asynchronous read port.
module core_link_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    // Entries are cleared on reset so the head word reads as zero while empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sys_defs.svh
// System-wide datapath sizing shared by the MAC array and its link blocks.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define MAC_MULT_NUM 2
`define IDATA_WIDTH  8

`endif

// File: rtl/core_link_fifo.sv
// Valid/ready link FIFO with occupancy count and almost-full flag.
// Define CORE_LINK_FIFO_BYPASS_EN to forward a write straight to the read side when empty.
`include "sys_defs.svh"

module core_link_fifo
    import core_link_pkg::*;
#(
    parameter int DATA_WIDTH   = (`MAC_MULT_NUM) * (`IDATA_WIDTH),
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_WIDTH-1:0]    hlink_wdata,
    input  logic                     hlink_wvalid,
    output logic                     hlink_wready,
    output logic [DATA_WIDTH-1:0]    hlink_rdata,
    output logic                     hlink_rvalid,
    input  logic                     hlink_rready,
    output logic [$clog2(DEPTH):0]   hlink_count,
    output logic                     hlink_afull
);

    localparam int PW = link_ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

    generate
        if (!link_is_pow2(DEPTH)) begin : g_bad_depth
            $error("core_link_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // Pointers wrap modulo 2*DEPTH, so their difference is the occupancy directly.
    assign hlink_count  = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty   = (hlink_count == '0);
    assign hlink_wready = (hlink_count != FULL_COUNT);
    assign hlink_afull  = (int'(hlink_count) >= AFULL_THRESH);

`ifdef CORE_LINK_FIFO_BYPASS_EN
    // An empty FIFO shows the incoming word at once; it is stored only if not taken.
    assign hlink_rvalid = !fifo_empty || hlink_wvalid;
    assign hlink_rdata  = (fifo_empty && hlink_wvalid) ? hlink_wdata : mem_rdata;
    assign push         = hlink_wvalid && hlink_wready && !(fifo_empty && hlink_rready);
    assign pop          = !fifo_empty && hlink_rready;
`else
    assign hlink_rvalid = !fifo_empty;
    assign hlink_rdata  = mem_rdata;
    assign push         = hlink_wvalid && hlink_wready;
    assign pop          = hlink_rvalid && hlink_rready;
`endif

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    core_link_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (hlink_wdata),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_core_link_fifo.sv
// Directed bench for core_link_fifo at DATA_WIDTH=16, DEPTH=4, AFULL_THRESH=3.
module tb_core_link_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] hlink_wdata;
    logic        hlink_wvalid;
    logic        hlink_wready;
    logic [15:0] hlink_rdata;
    logic        hlink_rvalid;
    logic        hlink_rready;
    logic [2:0]  hlink_count;
    logic        hlink_afull;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_link_fifo #(
        .DATA_WIDTH   (16),
        .DEPTH        (4),
        .AFULL_THRESH (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .hlink_wdata  (hlink_wdata),
        .hlink_wvalid (hlink_wvalid),
        .hlink_wready (hlink_wready),
        .hlink_rdata  (hlink_rdata),
        .hlink_rvalid (hlink_rvalid),
        .hlink_rready (hlink_rready),
        .hlink_count  (hlink_count),
        .hlink_afull  (hlink_afull)
    );

    // Every task starts and ends just after a falling edge; checks sample 1ns later.
    task automatic test_reset();
        rstn = 1'b0; hlink_wdata = 16'h0; hlink_wvalid = 1'b0; hlink_rready = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd0 || hlink_rvalid !== 1'b0 || hlink_wready !== 1'b1 ||
            hlink_afull !== 1'b0 || hlink_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state got cnt=%0d rv=%b wr=%b af=%b rd=%h exp cnt=0 rv=0 wr=1 af=0 rd=0000",
                     hlink_count, hlink_rvalid, hlink_wready, hlink_afull, hlink_rdata);
        end
        $display("reset: cnt=%0d rv=%b wr=%b af=%b", hlink_count, hlink_rvalid, hlink_wready, hlink_afull);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        hlink_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hlink_wvalid = 1'b1;
            hlink_wdata  = 16'(i + 1);
            #1;
            n_checks++;
            if (hlink_count !== 3'(i) || hlink_afull !== (i >= 3) || hlink_wready !== (i < 4)) begin
                n_fail++;
                $display("FAIL fill_flags push=%0d got cnt=%0d af=%b wr=%b exp cnt=%0d af=%b wr=%b",
                         i + 1, hlink_count, hlink_afull, hlink_wready, i, (i >= 3), (i < 4));
            end
            $display("fill: push %h cnt=%0d af=%b wr=%b", hlink_wdata, hlink_count, hlink_afull, hlink_wready);
            @(negedge clk);
        end
        hlink_wvalid = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd4 || hlink_rdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL fill_fifth_refused got cnt=%0d rd=%h exp cnt=4 rd=0001", hlink_count, hlink_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_drain();
        hlink_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (hlink_rvalid !== 1'b1 || hlink_rdata !== 16'(i + 1) || hlink_count !== 3'(4 - i)) begin
                n_fail++;
                $display("FAIL drain_word i=%0d got rv=%b rd=%h cnt=%0d exp rv=1 rd=%h cnt=%0d",
                         i, hlink_rvalid, hlink_rdata, hlink_count, 16'(i + 1), 4 - i);
            end
            $display("drain: pop %h cnt=%0d", hlink_rdata, hlink_count);
            @(negedge clk);
        end
        // rready held while empty must not disturb state
        @(negedge clk);
        #1;
        n_checks++;
        if (hlink_rvalid !== 1'b0 || hlink_count !== 3'd0 || hlink_wready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty got rv=%b cnt=%0d wr=%b exp rv=0 cnt=0 wr=1",
                     hlink_rvalid, hlink_count, hlink_wready);
        end
        hlink_rready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        hlink_rready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            hlink_wvalid = 1'b1;
            hlink_wdata  = 16'(16'h0010 + k);
            #1;
            if (k > 0) begin
                n_checks++;
                if (hlink_count !== 3'd1 || hlink_rvalid !== 1'b1 || hlink_rdata !== 16'(16'h0010 + k - 1)) begin
                    n_fail++;
                    $display("FAIL stream k=%0d got cnt=%0d rv=%b rd=%h exp cnt=1 rv=1 rd=%h",
                             k, hlink_count, hlink_rvalid, hlink_rdata, 16'(16'h0010 + k - 1));
                end
            end
            $display("stream: push %h out %h cnt=%0d", hlink_wdata, hlink_rdata, hlink_count);
            @(negedge clk);
        end
        hlink_wvalid = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd1 || hlink_rdata !== 16'h0019) begin
            n_fail++;
            $display("FAIL stream_last got cnt=%0d rd=%h exp cnt=1 rd=0019", hlink_count, hlink_rdata);
        end
        @(negedge clk);
        hlink_rready = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd0 || hlink_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_empty got cnt=%0d rv=%b exp cnt=0 rv=0", hlink_count, hlink_rvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_full_pop();
        hlink_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hlink_wvalid = 1'b1;
            hlink_wdata  = 16'(16'h0021 + i);
            @(negedge clk);
        end
        hlink_wdata  = 16'h0025;
        hlink_rready = 1'b1;
        #1;
        n_checks++;
        if (hlink_wready !== 1'b0 || hlink_rdata !== 16'h0021 || hlink_count !== 3'd4) begin
            n_fail++;
            $display("FAIL fullpop_before got wr=%b rd=%h cnt=%0d exp wr=0 rd=0021 cnt=4",
                     hlink_wready, hlink_rdata, hlink_count);
        end
        $display("fullpop: push %h refused, pop %h", hlink_wdata, hlink_rdata);
        @(negedge clk);
        hlink_wvalid = 1'b0;
        hlink_rready = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd3 || hlink_rdata !== 16'h0022 || hlink_afull !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_after got cnt=%0d rd=%h af=%b exp cnt=3 rd=0022 af=1",
                     hlink_count, hlink_rdata, hlink_afull);
        end
        @(negedge clk);
        hlink_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (hlink_rvalid !== 1'b1 || hlink_rdata !== 16'(16'h0022 + i)) begin
                n_fail++;
                $display("FAIL fullpop_drain i=%0d got rv=%b rd=%h exp rv=1 rd=%h",
                         i, hlink_rvalid, hlink_rdata, 16'(16'h0022 + i));
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (hlink_rvalid !== 1'b0 || hlink_count !== 3'd0) begin
            n_fail++;
            $display("FAIL fullpop_no_refused_word got rv=%b cnt=%0d rd=%h exp rv=0 cnt=0",
                     hlink_rvalid, hlink_count, hlink_rdata);
        end
        hlink_rready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        hlink_rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hlink_wvalid = 1'b1;
            hlink_wdata  = 16'(16'h0031 + i);
            @(negedge clk);
        end
        hlink_wvalid = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd2) begin
            n_fail++;
            $display("FAIL rstmid_pre got cnt=%0d exp cnt=2", hlink_count);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (hlink_count !== 3'd0 || hlink_rvalid !== 1'b0 || hlink_wready !== 1'b1 ||
            hlink_afull !== 1'b0 || hlink_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_async got cnt=%0d rv=%b wr=%b af=%b rd=%h exp cnt=0 rv=0 wr=1 af=0 rd=0000",
                     hlink_count, hlink_rvalid, hlink_wready, hlink_afull, hlink_rdata);
        end
        $display("rstmid: reset asserted cnt=%0d rv=%b", hlink_count, hlink_rvalid);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        hlink_wvalid = 1'b1;
        hlink_wdata  = 16'h00AA;
        @(negedge clk);
        hlink_wvalid = 1'b0;
        #1;
        n_checks++;
        if (hlink_rvalid !== 1'b1 || hlink_rdata !== 16'h00AA || hlink_count !== 3'd1) begin
            n_fail++;
            $display("FAIL rstmid_first got rv=%b rd=%h cnt=%0d exp rv=1 rd=00aa cnt=1",
                     hlink_rvalid, hlink_rdata, hlink_count);
        end
        hlink_rready = 1'b1;
        @(negedge clk);
        hlink_rready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        hlink_wvalid = 1'b1;
        hlink_wdata  = 16'h00BB;
        hlink_rready = 1'b1;
        #1;
        n_checks++;
`ifdef CORE_LINK_FIFO_BYPASS_EN
        if (hlink_rvalid !== 1'b1 || hlink_rdata !== 16'h00BB || hlink_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got rv=%b rd=%h cnt=%0d exp rv=1 rd=00bb cnt=0",
                     hlink_rvalid, hlink_rdata, hlink_count);
        end
`else
        if (hlink_rvalid !== 1'b0 || hlink_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_off_same_cycle got rv=%b cnt=%0d exp rv=0 cnt=0", hlink_rvalid, hlink_count);
        end
`endif
        $display("bypass: push %h rv=%b rd=%h", hlink_wdata, hlink_rvalid, hlink_rdata);
        @(negedge clk);
        hlink_wvalid = 1'b0;
        hlink_rready = 1'b0;
        #1;
        n_checks++;
`ifdef CORE_LINK_FIFO_BYPASS_EN
        if (hlink_rvalid !== 1'b0 || hlink_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_not_stored got rv=%b cnt=%0d exp rv=0 cnt=0", hlink_rvalid, hlink_count);
        end
`else
        if (hlink_rvalid !== 1'b1 || hlink_rdata !== 16'h00BB || hlink_count !== 3'd1) begin
            n_fail++;
            $display("FAIL bypass_off_next got rv=%b rd=%h cnt=%0d exp rv=1 rd=00bb cnt=1",
                     hlink_rvalid, hlink_rdata, hlink_count);
        end
`endif
        hlink_rready = 1'b1;
        @(negedge clk);
        hlink_rready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_pop();
        test_reset_mid();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
